lms_pair_rd_sched: RTL

Read-side scheduler for the two 16-bit × 1024 LMS sample FIFOs: the reference-signal FIFO (x) and the desired-signal FIFO (d). It waits until both FIFOs hold a full frame, then pops them in lockstep and delivers time-aligned (x, d) pairs with a last-of-frame marker to the LMS filter core over a valid/ready stream. It sits in the read clock domain between the FIFO pair and the LMS core, and absorbs the FIFO's one-cycle read latency and downstream back-pressure in a 2-entry skid buffer.

---
 rtl/lms_pkg.sv | 19 +
 rtl/lms_pair_skid.sv | 52 +++++
 rtl/lms_pair_rd_sched.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/lms_pkg.sv
// Shared types for the LMS (x, d) pair read scheduler: FSM states, default widths and the pair record.
package lms_pkg;

  localparam int LMS_DATA_W = 16;
  localparam int LMS_LVL_W  = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [LMS_DATA_W-1:0] x;
    logic [LMS_DATA_W-1:0] d;
    logic                  last;
  } pair_t;

endpackage

// File: rtl/lms_pair_skid.sv
// Two-entry FIFO of pair records; the head entry is always visible on rd_data.
module lms_pair_skid
  import lms_pkg::*;
#(
  parameter type T = pair_t
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       wr,
  input  T           wr_data,
  input  logic       rd,
  output T           rd_data,
  output logic [1:0] count
);

  T           mem_reg [2];
  logic       wr_ptr_reg;
  logic       rd_ptr_reg;
  logic [1:0] count_reg;
  logic       do_rd;

  // A read request against an empty buffer is ignored.
  assign do_rd = rd && (count_reg != 2'd0);

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < 2; i++) begin
        mem_reg[i] <= '0;
      end
      wr_ptr_reg <= 1'b0;
      rd_ptr_reg <= 1'b0;
      count_reg  <= 2'd0;
    end else begin
      if (wr) begin
        mem_reg[wr_ptr_reg] <= wr_data;
        wr_ptr_reg          <= ~wr_ptr_reg;
      end
      if (do_rd) begin
        rd_ptr_reg <= ~rd_ptr_reg;
      end
      case ({wr, do_rd})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem_reg[rd_ptr_reg];
  assign count   = count_reg;

endmodule

// File: rtl/lms_pair_rd_sched.sv
// Frame-based lockstep reader for the x/d LMS FIFOs feeding a valid/ready pair stream.
// Define LMS_PAIR_SCHED_STATS_EN to add the frame_cnt / stall_cnt statistics outputs.
module lms_pair_rd_sched
  import lms_pkg::*;
#(
  parameter int DATA_W    = LMS_DATA_W,
  parameter int LVL_W     = LMS_LVL_W,
  parameter int FRAME_LEN = 32
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              enable,
  output logic              x_rd_en,
  input  logic [DATA_W-1:0] x_rd_data,
  input  logic              x_rd_empty,
  input  logic [LVL_W-1:0]  x_rd_water_level,
  output logic              d_rd_en,
  input  logic [DATA_W-1:0] d_rd_data,
  input  logic              d_rd_empty,
  input  logic [LVL_W-1:0]  d_rd_water_level,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_x,
  output logic [DATA_W-1:0] m_d,
  output logic              m_last,
  output logic              busy,
  output logic              frame_done
`ifdef LMS_PAIR_SCHED_STATS_EN
  ,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int REM_W = $clog2(FRAME_LEN + 1);
  localparam logic [REM_W-1:0] FRAME_REM = REM_W'(FRAME_LEN);
  localparam logic [LVL_W-1:0] FRAME_LVL = LVL_W'(FRAME_LEN);

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] d;
    logic              last;
  } pair_w_t;

  state_t           state_reg, state_next;
  logic [REM_W-1:0] remain_reg, remain_next;
  logic             inflight_reg;
  logic             inflight_last_reg;
  logic [1:0]       buf_cnt;
  logic             fifo_empty;
  logic             credit_ok;
  logic             pop;
  logic             start;
  logic             drained;
  pair_w_t          wr_pair;
  pair_w_t          head;

  assign fifo_empty = x_rd_empty | d_rd_empty;
  // Entries already buffered plus the one still in the FIFO read pipeline must leave a free slot.
  assign credit_ok  = ({1'b0, buf_cnt} + {2'b00, inflight_reg}) < 3'd2;
  assign pop        = (state_reg == BURST) && (remain_reg != '0) && !fifo_empty && credit_ok;
  assign start      = enable && (x_rd_water_level >= FRAME_LVL) && (d_rd_water_level >= FRAME_LVL);
  assign drained    = (buf_cnt == 2'd0) && !inflight_reg;

  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = BURST;
          remain_next = FRAME_REM;
        end
      end
      BURST: begin
        if (pop) begin
          remain_next = remain_reg - 1'b1;
          if (remain_reg == REM_W'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (drained) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_reg         <= IDLE;
      remain_reg        <= '0;
      inflight_reg      <= 1'b0;
      inflight_last_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      remain_reg        <= remain_next;
      inflight_reg      <= pop;
      inflight_last_reg <= pop && (remain_reg == REM_W'(1));
    end
  end

  // FIFO data arrives one cycle after the pop, together with its last tag.
  assign wr_pair.x    = x_rd_data;
  assign wr_pair.d    = d_rd_data;
  assign wr_pair.last = inflight_last_reg;

  lms_pair_skid #(
    .T(pair_w_t)
  ) u_skid (
    .clk     (rd_clk),
    .srst    (rd_rst),
    .wr      (inflight_reg),
    .wr_data (wr_pair),
    .rd      (m_ready),
    .rd_data (head),
    .count   (buf_cnt)
  );

  assign x_rd_en    = pop;
  assign d_rd_en    = pop;
  assign m_valid    = (buf_cnt != 2'd0);
  assign m_x        = head.x;
  assign m_d        = head.d;
  assign m_last     = head.last;
  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == DRAIN) && drained;

`ifdef LMS_PAIR_SCHED_STATS_EN
  logic [15:0] frame_cnt_reg;
  logic [15:0] stall_cnt_reg;

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      frame_cnt_reg <= 16'd0;
      stall_cnt_reg <= 16'd0;
    end else begin
      if (frame_done) begin
        frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
      // Only starvation counts as a stall; credit back-pressure does not.
      if ((state_reg == BURST) && (remain_reg != '0) && fifo_empty && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
    end
  end

  assign frame_cnt = frame_cnt_reg;
  assign stall_cnt = stall_cnt_reg;
`endif

endmodule
